mem_access_ctrl: RTL

Sequencer for the MEM stage's data-memory port. It takes the per-instruction memory control produced in ID and carried down the pipeline: read/write flags, sign-extend flag, 4-bit size select, write data and effective address. It runs one handshaked access on the data-RAM bus, and stalls the pipeline until the access completes. It also performs byte-lane steering for stores and lane extraction/extension for loads, returning a 32-bit load result to the MEM/WB path.

---
 rtl/mem_access_ctrl_if.sv | 35 +++
 rtl/mem_access_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Data-RAM bus between the MEM-stage access controller and the data memory.
//   One request is outstanding at a time: the master holds ram_en and all
//   request fields stable until the slave answers with ram_ready.
//
//   Signals
//     ram_en          master -> slave  bus request
//     ram_write_en    master -> slave  per-byte write strobes (0000 = read)
//     ram_addr        master -> slave  word-aligned byte address
//     ram_write_data  master -> slave  lane-steered store data
//     ram_ready       slave -> master  completion, meaningful only while ram_en=1
//     ram_read_data   slave -> master  read word, valid on the ram_ready cycle
//
//   Modports: master (access controller), slave (memory model / RAM wrapper).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              ram_en;
  logic [3:0]        ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_write_data;
  logic              ram_ready;
  logic [DATA_W-1:0] ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ready, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ready, ram_read_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage sequencer for the data-memory port. Accepts the per-instruction
//   memory control carried down from ID, runs exactly one handshaked access on
//   the data-RAM bus, stalls the pipeline until it completes, steers store
//   bytes onto the right lanes and extracts/extends load bytes.
//
//   FSM: IDLE -> BUSY (bus request held) -> DONE (result presented) -> IDLE.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     flush               blocks the start of a new access
//     mem_read_flag       load (lb, lbu, lw)
//     mem_write_flag      store (sb, sw); wins when both flags are set
//     mem_sign_ext_flag   sign-extend loaded byte (lb)
//     mem_sel             0001 byte, 1111 word, anything else no access
//     mem_addr            effective byte address
//     mem_write_data      store data (low byte for sb)
//     stall_req           hold the earlier pipeline stages
//     load_data           extended load result (registered)
//     load_valid          load_data valid, high only in DONE for live loads
//     addr_err            misaligned word access refused (alignment build only)
//     ram                 data-RAM bus, master side
//
//   Build option: define MEM_ALIGN_CHECK_EN to refuse word accesses whose
//   address is not word aligned and to expose addr_err. Without it the low
//   address bits are ignored for words and the aligned word is accessed.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_ext_flag,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic              stall_req,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              addr_err,
`endif
  mem_access_ctrl_if.master ram
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              ram_en_q;
  logic [3:0]        ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wd_q;
  logic              write_q;     // latched access is a store
  logic              word_q;      // latched access is a word access
  logic              sign_q;      // latched sign-extend flag
  logic [1:0]        addr_lo_q;   // byte lane of the latched access
  logic              flushed_q;   // flush seen while the bus cycle was open
  logic [DATA_W-1:0] load_data_q;
  logic              load_valid_q;

  // Request decode
  logic              sel_byte;
  logic              sel_word;
  logic              access_ok;
  logic              start;
  logic [3:0]        we_d;
  logic [DATA_W-1:0] wd_d;
  logic [ADDR_W-1:0] addr_d;

  assign sel_byte = (mem_sel == 4'b0001);
  assign sel_word = (mem_sel == 4'b1111);

  // A live memory instruction with a legal size select, not being flushed.
  // Reset also suppresses it so stall_req reads 0 while rst is held.
  assign access_ok = (mem_read_flag | mem_write_flag) & (sel_byte | sel_word)
                   & ~flush & ~rst;

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = sel_word & (mem_addr[1:0] != 2'b00);
  assign start      = (state_q == IDLE) & access_ok & ~misaligned;
  assign addr_err   = (state_q == IDLE) & access_ok & misaligned;
`else
  assign start      = (state_q == IDLE) & access_ok;
`endif

  // Store steering: bytes are replicated to every lane and the strobe picks
  // the one addressed; words go straight through. Reads carry no strobes.
  always_comb begin
    we_d = 4'b0000;
    wd_d = mem_write_data;
    if (sel_byte) begin
      wd_d = {4{mem_write_data[7:0]}};
      if (mem_write_flag) begin
        we_d = 4'b0001 << mem_addr[1:0];
      end
    end else if (mem_write_flag) begin
      we_d = 4'b1111;
    end
  end

  assign addr_d = {mem_addr[ADDR_W-1:2], 2'b00};

  // Load extraction from the live read word, captured on the ram_ready cycle.
  logic [7:0]        lane;
  logic [DATA_W-1:0] load_ext;

  always_comb begin
    lane     = ram.ram_read_data[{addr_lo_q, 3'b000} +: 8];
    load_ext = {{(DATA_W-8){1'b0}}, lane};
    if (word_q) begin
      load_ext = ram.ram_read_data;
    end else if (sign_q) begin
      load_ext = {{(DATA_W-8){lane[7]}}, lane};
    end
  end

  // Single sequential block: state plus every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 4'b0000;
      ram_addr_q   <= '0;
      ram_wd_q     <= '0;
      write_q      <= 1'b0;
      word_q       <= 1'b0;
      sign_q       <= 1'b0;
      addr_lo_q    <= 2'b00;
      flushed_q    <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          load_valid_q <= 1'b0;
          if (start) begin
            state_q    <= BUSY;
            ram_en_q   <= 1'b1;
            ram_we_q   <= we_d;
            ram_addr_q <= addr_d;
            ram_wd_q   <= wd_d;
            write_q    <= mem_write_flag;
            word_q     <= sel_word;
            sign_q     <= mem_sign_ext_flag;
            addr_lo_q  <= mem_addr[1:0];
            flushed_q  <= 1'b0;
          end
        end

        BUSY: begin
          // A flush never aborts the bus cycle; it only hides the result.
          if (flush) begin
            flushed_q <= 1'b1;
          end
          if (ram.ram_ready) begin
            state_q      <= DONE;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'b0000;
            if (!write_q) begin
              load_data_q <= load_ext;
            end
            load_valid_q <= ~write_q & ~flushed_q & ~flush;
          end
        end

        DONE: begin
          // The pipeline advances this cycle, so never reissue.
          state_q      <= IDLE;
          load_valid_q <= 1'b0;
        end

        default: begin
          state_q      <= IDLE;
          ram_en_q     <= 1'b0;
          load_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_req          = start | (state_q == BUSY);
  assign load_data          = load_data_q;
  assign load_valid         = load_valid_q;
  assign ram.ram_en         = ram_en_q;
  assign ram.ram_write_en   = ram_we_q;
  assign ram.ram_addr       = ram_addr_q;
  assign ram.ram_write_data = ram_wd_q;

endmodule
